// File: rtl/alu_nibble_serial.sv
// ============================================================================
// alu_nibble_serial : nibble-serial ALU, one 4-bit slice per clock, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_nibble_serial #(
  parameter int WIDTH    = 8,
  parameter int H_NIBBLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_H    = KW'(H_NIBBLE);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_ADC = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_SBC = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_CP  = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             h_q, h_d;
  logic             nz_q, nz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic       is_sub, is_arith, is_logic;
  logic [3:0] a_nib, b_nib, b_eff, logic_nib, res_nib, z_nib;
  logic [4:0] sum;
  logic       h_now, z_final, carry_init;

  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_ADC) || is_sub;
  assign is_logic = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);

  always_comb begin
    a_nib = a_q[3:0];
    b_nib = b_q[3:0];
    b_eff = is_sub ? ~b_nib : b_nib;
    sum   = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry_q};

    logic_nib = a_nib | b_nib;
    if (op_q == OP_AND) begin
      logic_nib = a_nib & b_nib;
    end else if (op_q == OP_XOR) begin
      logic_nib = a_nib ^ b_nib;
    end

    // CP reports the subtraction's flags but returns operand A untouched.
    res_nib = a_nib;
    z_nib   = a_nib;
    if (is_arith) begin
      z_nib = sum[3:0];
      if (op_q != OP_CP) begin
        res_nib = sum[3:0];
      end
    end else if (is_logic) begin
      res_nib = logic_nib;
      z_nib   = logic_nib;
    end

    h_now   = (k_q == K_H) ? sum[4] : h_q;
    z_final = ~(nz_q | (|z_nib));

    // Subtraction runs as A + ~B + c, so a set carry-in means "no borrow".
    case (in_op)
      OP_ADC:        carry_init = in_flags[0];
      OP_SBC:        carry_init = ~in_flags[0];
      OP_SUB, OP_CP: carry_init = 1'b1;
      default:       carry_init = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    flags_d      = flags_q;
    res_d        = res_q;
    carry_d      = carry_q;
    h_d          = h_q;
    nz_d         = nz_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = in_op;
          a_d        = in_a;
          b_d        = in_b;
          flags_d    = in_flags;
          k_d        = '0;
          carry_d    = carry_init;
          h_d        = 1'b0;
          nz_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = (res_q >> 4) | {res_nib, {(WIDTH-4){1'b0}}};
        carry_d = sum[4];
        h_d     = h_now;
        nz_d    = nz_q | (|z_nib);
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d      = S_DONE;
          out_valid_d  = 1'b1;
          out_result_d = res_d;
          if (is_arith) begin
            out_flags_d = {z_final, is_sub, h_now ^ is_sub, sum[4] ^ is_sub};
          end else if (is_logic) begin
            out_flags_d = {z_final, 1'b0, op_q == OP_AND, 1'b0};
          end else begin
            out_flags_d = flags_q;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      flags_q      <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      h_q          <= 1'b0;
      nz_q         <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      flags_q      <= flags_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      h_q          <= h_d;
      nz_q         <= nz_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_nibble_serial.sv
// ============================================================================
// tb_alu_nibble_serial : directed + random checks of 8-bit and 16-bit instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_nibble_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic [4:0]  iop  [2];
  logic [15:0] ia   [2];
  logic [15:0] ib   [2];
  logic [3:0]  ifl  [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [3:0]  ofl  [2];
  logic [7:0]  res8;
  logic [15:0] res16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_nibble_serial #(.WIDTH(8), .H_NIBBLE(0)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv[0]),
    .in_ready   (ir[0]),
    .in_op      (iop[0]),
    .in_a       (ia[0][7:0]),
    .in_b       (ib[0][7:0]),
    .in_flags   (ifl[0]),
    .out_valid  (ov[0]),
    .out_ready  (ordy[0]),
    .out_result (res8),
    .out_flags  (ofl[0])
  );

  alu_nibble_serial #(.WIDTH(16), .H_NIBBLE(2)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv[1]),
    .in_ready   (ir[1]),
    .in_op      (iop[1]),
    .in_a       (ia[1]),
    .in_b       (ib[1]),
    .in_flags   (ifl[1]),
    .out_valid  (ov[1]),
    .out_ready  (ordy[1]),
    .out_result (res16),
    .out_flags  (ofl[1])
  );

  function automatic logic [15:0] get_res(int sel);
    return (sel == 0) ? {8'h00, res8} : res16;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-word integer arithmetic, borrow/carry from comparisons.
  function automatic logic [19:0] model(int w, int hn, logic [4:0] op,
                                        logic [15:0] a, logic [15:0] b, logic [3:0] fl);
    longint mask = (64'd1 << w) - 1;
    longint hm   = (64'd1 << (4 * (hn + 1))) - 1;
    longint la   = longint'(a) & mask;
    longint lb   = longint'(b) & mask;
    longint ci;
    longint r;
    logic [15:0] res;
    logic [15:0] shown;
    logic z, n, h, c;
    case (op)
      5'd0, 5'd1: begin
        ci    = (op == 5'd1) ? longint'(fl[0]) : 0;
        r     = la + lb + ci;
        res   = 16'(r & mask);
        c     = ((r >> w) & 1) != 0;
        h     = ((la & hm) + (lb & hm) + ci) > hm;
        n     = 1'b0;
        shown = res;
      end
      5'd2, 5'd3, 5'd7: begin
        ci    = (op == 5'd3) ? longint'(fl[0]) : 0;
        res   = 16'((la - lb - ci) & mask);
        c     = la < (lb + ci);
        h     = (la & hm) < ((lb & hm) + ci);
        n     = 1'b1;
        shown = (op == 5'd7) ? 16'(la) : res;
      end
      5'd4, 5'd5, 5'd6: begin
        if (op == 5'd4)      res = 16'(la & lb);
        else if (op == 5'd5) res = 16'(la ^ lb);
        else                 res = 16'(la | lb);
        c     = 1'b0;
        h     = (op == 5'd4);
        n     = 1'b0;
        shown = res;
      end
      default: return {16'(la), fl};
    endcase
    z = (res == 16'h0000);
    return {shown, z, n, h, c};
  endfunction

  task automatic xact(int sel, logic [4:0] op, logic [15:0] a, logic [15:0] b,
                      logic [3:0] fl, int hold);
    int w = (sel == 0) ? 8 : 16;
    int hn = (sel == 0) ? 0 : 2;
    logic [19:0] exp = model(w, hn, op, a, b, fl);
    logic [15:0] r0;
    logic [3:0]  f0;
    int n = 0;
    int lat = 0;
    while (!ir[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 32'(ir[sel]), 32'd1);
    iv[sel] = 1'b1; iop[sel] = op; ia[sel] = a; ib[sel] = b; ifl[sel] = fl;
    @(negedge clk);
    iv[sel] = 1'b0;
    chk("busy_ready", 32'(ir[sel]), 32'd0);
    while (!ov[sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(w / 4));
    chk("result", 32'(get_res(sel)), 32'(exp[19:4]));
    chk("flags", 32'(ofl[sel]), 32'(exp[3:0]));
    r0 = get_res(sel);
    f0 = ofl[sel];
    for (int h = 0; h < hold; h++) begin
      iv[sel] = 1'b1; iop[sel] = 5'($urandom); ia[sel] = 16'($urandom); ib[sel] = 16'($urandom);
      @(negedge clk);
      chk("hold_result", 32'(get_res(sel)), 32'(r0));
      chk("hold_flags", 32'(ofl[sel]), 32'(f0));
      chk("hold_valid", 32'(ov[sel]), 32'd1);
      chk("hold_ready", 32'(ir[sel]), 32'd0);
    end
    iv[sel] = 1'b0;
    ordy[sel] = 1'b1;
    @(negedge clk);
    ordy[sel] = 1'b0;
    chk("post_valid", 32'(ov[sel]), 32'd0);
    chk("post_ready", 32'(ir[sel]), 32'd1);
  endtask

  task automatic chk_reset_state(int sel);
    chk("rst_valid", 32'(ov[sel]), 32'd0);
    chk("rst_ready", 32'(ir[sel]), 32'd1);
    chk("rst_result", 32'(get_res(sel)), 32'd0);
    chk("rst_flags", 32'(ofl[sel]), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; iop[s] = '0; ia[s] = '0; ib[s] = '0; ifl[s] = '0; ordy[s] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state(0);
    chk_reset_state(1);

    xact(0, 5'b00000, 16'h003A, 16'h00C6, 4'b0000, 0);
    xact(0, 5'b00010, 16'h003E, 16'h000F, 4'b0000, 0);
    xact(0, 5'b00011, 16'h0010, 16'h0010, 4'b0001, 0);
    xact(1, 5'b00000, 16'h0FFF, 16'h0001, 4'b0000, 0);
    xact(0, 5'b00111, 16'h0042, 16'h0042, 4'b0000, 0);
    xact(0, 5'b00100, 16'h00F0, 16'h000F, 4'b0000, 5);
    xact(0, 5'b10101, 16'h005A, 16'h0011, 4'b1010, 1);
    xact(1, 5'b00111, 16'h1234, 16'h1235, 4'b0000, 0);

    // Abort mid-run: outputs must clear and nothing may be delivered.
    iv[0] = 1'b1; iop[0] = 5'b00000; ia[0] = 16'h0077; ib[0] = 16'h0011;
    @(negedge clk);
    iv[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state(0);
    xact(0, 5'b00001, 16'h0001, 16'h0001, 4'b0001, 0);
    chk("adc_after_rst", 32'(res8), 32'h03);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      xact(i % 2, op, 16'($urandom), 16'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
